// File: rtl/keypad_pkg.sv
// Shared types and seven-segment helpers for the keypad scanner and its display.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } kp_state_e;

  localparam logic [6:0] BLANK_SEG = 7'b1111111;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = BLANK_SEG;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/kp_debounce_fsm.sv
// Column synchronizer, row scan and press/release debounce FSM.
// Exposes the same-cycle accept/code alongside the registered key strobe so the display history updates in lockstep.
module kp_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int SCAN_DIV        = 4096,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int CODE_W          = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [COLS-1:0]   i_cols,
  output logic [ROWS-1:0]   o_rows,
  output logic              o_accept,
  output logic [CODE_W-1:0] o_accept_code,
  output logic              o_key_valid,
  output logic [CODE_W-1:0] o_key_code
);

  // state      | meaning
  // SCAN       | rotate rows, sample synced cols in last cycle of each row window
  // DB_PRESS   | row held, count while captured column stays low
  // HELD       | press accepted, wait for all columns high
  // DB_RELEASE | count while all columns stay high, then resume scanning

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW  = $clog2(SCAN_DIV);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);

  logic [COLS-1:0]   r_sync1;
  logic [COLS-1:0]   r_sync2;
  kp_state_e         r_state;
  kp_state_e         w_state_nxt;
  logic [RW-1:0]     r_row;
  logic [RW-1:0]     w_row_nxt;
  logic [ROWS-1:0]   r_rows;
  logic [SW-1:0]     r_div;
  logic [SW-1:0]     w_div_nxt;
  logic [DBW-1:0]    r_cnt;
  logic [DBW-1:0]    w_cnt_nxt;
  logic [CW-1:0]     r_col;
  logic [CW-1:0]     w_col_nxt;
  logic [CW-1:0]     w_low_col;
  logic              w_accept;
  logic [CODE_W-1:0] w_code;
  logic              r_key_valid;
  logic [CODE_W-1:0] r_key_code;

  logic w_div_last;
  logic w_cnt_last;
  logic w_any_low;
  logic w_col_low;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= i_cols;
      r_sync2 <= r_sync1;
    end
  end

  assign w_div_last = (r_div == SW'(SCAN_DIV - 1));
  assign w_cnt_last = (r_cnt == DBW'(DEBOUNCE_CYCLES - 1));
  assign w_any_low  = ~&r_sync2;
  assign w_col_low  = ~r_sync2[r_col];
  assign w_code     = CODE_W'(r_row) * CODE_W'(COLS) + CODE_W'(r_col);

  // Lowest-index low column wins when several are down.
  always_comb begin
    w_low_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!r_sync2[c]) w_low_col = CW'(c);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= SCAN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SCAN:       if (w_div_last && w_any_low) w_state_nxt = DB_PRESS;
      DB_PRESS: begin
        if (!w_col_low)      w_state_nxt = SCAN;
        else if (w_cnt_last) w_state_nxt = HELD;
      end
      HELD:       if (!w_any_low) w_state_nxt = DB_RELEASE;
      DB_RELEASE: begin
        if (w_any_low)       w_state_nxt = HELD;
        else if (w_cnt_last) w_state_nxt = SCAN;
      end
      default:    w_state_nxt = SCAN;
    endcase
  end

  // Counters fall back to zero on every exit, so each state starts with a fresh count.
  always_comb begin
    w_accept  = 1'b0;
    w_cnt_nxt = '0;
    w_div_nxt = '0;
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    case (r_state)
      SCAN: begin
        if (w_div_last) begin
          if (w_any_low) w_col_nxt = w_low_col;
          else           w_row_nxt = (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      DB_PRESS: begin
        if (w_col_low) begin
          if (w_cnt_last) w_accept  = 1'b1;
          else            w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DB_RELEASE: begin
        if (!w_any_low && !w_cnt_last) w_cnt_nxt = r_cnt + 1'b1;
      end
      default: begin
        w_accept = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_row       <= '0;
      r_rows      <= ~ROWS'(1);
      r_div       <= '0;
      r_cnt       <= '0;
      r_col       <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_row       <= w_row_nxt;
      r_rows      <= ~(ROWS'(1) << w_row_nxt);
      r_div       <= w_div_nxt;
      r_cnt       <= w_cnt_nxt;
      r_col       <= w_col_nxt;
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= w_code;
    end
  end

  assign o_rows        = r_rows;
  assign o_accept      = w_accept;
  assign o_accept_code = w_code;
  assign o_key_valid   = r_key_valid;
  assign o_key_code    = r_key_code;

endmodule

// File: rtl/keypad_scan_display.sv
// Matrix keypad scanner with key history multiplexed onto one shared 7-segment bus.
// Define KEYPAD_BLANK_EN to blank digits that have never received a key.
module keypad_scan_display
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int DIGITS          = 2,
  parameter int SCAN_DIV        = 4096,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int MUX_DIV         = 65536,
  localparam int CODE_W         = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [COLS-1:0]   i_cols,
  output logic [ROWS-1:0]   o_rows,
  output logic [6:0]        o_segout,
  output logic [DIGITS-1:0] o_dig_en,
  output logic              o_key_valid,
  output logic [CODE_W-1:0] o_key_code
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;

  logic              w_accept;
  logic [CODE_W-1:0] w_acc_code;
  logic [3:0]        w_nib;
  logic [3:0]        r_hist     [DIGITS];
  logic [3:0]        w_hist_nxt [DIGITS];
  logic [MW-1:0]     r_mdiv;
  logic [MW-1:0]     w_mdiv_nxt;
  logic [DW-1:0]     r_dig;
  logic [DW-1:0]     w_dig_nxt;
  logic [DIGITS-1:0] r_dig_en;
  logic [6:0]        r_seg;
  logic [6:0]        w_seg_nxt;
`ifdef KEYPAD_BLANK_EN
  logic [DIGITS-1:0] r_hval;
  logic [DIGITS-1:0] w_hval_nxt;
`endif

  kp_debounce_fsm #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CODE_W          (CODE_W)
  ) u_fsm (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_cols        (i_cols),
    .o_rows        (o_rows),
    .o_accept      (w_accept),
    .o_accept_code (w_acc_code),
    .o_key_valid   (o_key_valid),
    .o_key_code    (o_key_code)
  );

  if (CODE_W >= 4) begin : g_nib_trunc
    assign w_nib = w_acc_code[3:0];
  end else begin : g_nib_pad
    assign w_nib = {{(4 - CODE_W){1'b0}}, w_acc_code};
  end

  always_comb begin
    for (int d = 0; d < DIGITS; d++) w_hist_nxt[d] = r_hist[d];
    if (w_accept) begin
      w_hist_nxt[0] = w_nib;
      for (int d = 1; d < DIGITS; d++) w_hist_nxt[d] = r_hist[d-1];
    end
  end

`ifdef KEYPAD_BLANK_EN
  assign w_hval_nxt = w_accept ? ((r_hval << 1) | DIGITS'(1)) : r_hval;
`endif

  always_comb begin
    w_mdiv_nxt = r_mdiv + 1'b1;
    w_dig_nxt  = r_dig;
    if (r_mdiv == MW'(MUX_DIV - 1)) begin
      w_mdiv_nxt = '0;
      w_dig_nxt  = (r_dig == DW'(DIGITS - 1)) ? '0 : r_dig + 1'b1;
    end
  end

  // Decode from next-state history so segout tracks a new key in the same cycle as key_valid.
  always_comb begin
    w_seg_nxt = hex_to_seg(w_hist_nxt[w_dig_nxt]);
`ifdef KEYPAD_BLANK_EN
    if (!w_hval_nxt[w_dig_nxt]) w_seg_nxt = BLANK_SEG;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int d = 0; d < DIGITS; d++) r_hist[d] <= 4'h0;
      r_mdiv   <= '0;
      r_dig    <= '0;
      r_dig_en <= DIGITS'(1);
`ifdef KEYPAD_BLANK_EN
      r_hval   <= '0;
      r_seg    <= BLANK_SEG;
`else
      r_seg    <= hex_to_seg(4'h0);
`endif
    end else begin
      for (int d = 0; d < DIGITS; d++) r_hist[d] <= w_hist_nxt[d];
      r_mdiv   <= w_mdiv_nxt;
      r_dig    <= w_dig_nxt;
      r_dig_en <= DIGITS'(1) << w_dig_nxt;
`ifdef KEYPAD_BLANK_EN
      r_hval   <= w_hval_nxt;
`endif
      r_seg    <= w_seg_nxt;
    end
  end

  assign o_segout = r_seg;
  assign o_dig_en = r_dig_en;

endmodule

// File: tb/tb_keypad_scan_display.sv
// Directed self-checking bench for keypad_scan_display with a behavioural 4x4 key matrix.
module tb_keypad_scan_display;

  localparam logic [6:0] SEG0 = 7'h40;
  localparam logic [6:0] SEG3 = 7'h30;
  localparam logic [6:0] SEG5 = 7'h12;
  localparam logic [6:0] SEG6 = 7'h02;
  localparam logic [6:0] SEGA = 7'h08;
`ifdef KEYPAD_BLANK_EN
  localparam logic [6:0] EMPTY = 7'h7F;
`else
  localparam logic [6:0] EMPTY = SEG0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [6:0] segout;
  logic [1:0] dig_en;
  logic       key_valid;
  logic [3:0] key_code;
  logic [15:0] pressed;

  int total = 0;
  int bad   = 0;
  int nvalid = 0;

  keypad_scan_display #(
    .ROWS(4), .COLS(4), .DIGITS(2),
    .SCAN_DIV(4), .DEBOUNCE_CYCLES(8), .MUX_DIV(4)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_cols      (cols),
    .o_rows      (rows),
    .o_segout    (segout),
    .o_dig_en    (dig_en),
    .o_key_valid (key_valid),
    .o_key_code  (key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !rows[r]) cols[c] = 1'b0;
  end

  always @(posedge clk) if (key_valid === 1'b1) nvalid++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  function automatic logic [15:0] key(input int code);
    return 16'h1 << code;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (key_valid === 1'b1) begin seen = 1'b1; break; end
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_digits(input string tag, input logic [6:0] e0, input logic [6:0] e1);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (dig_en === 2'b01) begin seen = 1'b1; break; end
    end
    chk({tag, "_d0_found"}, 32'(seen), 32'd1);
    chk({tag, "_d0_seg"}, 32'(segout), 32'(e0));
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (dig_en === 2'b10) begin seen = 1'b1; break; end
    end
    chk({tag, "_d1_found"}, 32'(seen), 32'd1);
    chk({tag, "_d1_seg"}, 32'(segout), 32'(e1));
  endtask

  initial begin
    int n0;
    bit seen;
    logic [3:0] r0;
    logic [3:0] prev_rows;
    logic [1:0] prev_dig;

    reset   = 1'b1;
    pressed = '0;
    tick(3);
    chk("rst_rows", 32'(rows), 32'(4'b1110));
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_dig_en", 32'(dig_en), 32'(2'b01));
    chk("rst_seg", 32'(segout), 32'(EMPTY));

    // Code 6 (row 1, col 2) from reset: sampled at end of row-1 window, accepted 8 cycles later.
    pressed = key(6);
    reset   = 1'b0;
    tick(12);
    chk("t1_row_held", 32'(rows), 32'(4'b1101));
    tick(3);
    chk("t1_no_early_valid", 32'(key_valid), 32'd0);
    chk("t1_dig_en_pre", 32'(dig_en), 32'(2'b10));
    tick(1);
    chk("t1_valid", 32'(key_valid), 32'd1);
    chk("t1_code", 32'(key_code), 32'd6);
    chk("t1_dig_en_acc", 32'(dig_en), 32'(2'b01));
    chk("t1_seg_same_cycle", 32'(segout), 32'(SEG6));
    tick(1);
    chk("t1_strobe_width", 32'(key_valid), 32'd0);
    tick(23);
    pressed = '0;
    tick(30);
    chk("t1_one_valid", 32'(nvalid), 32'd1);
    check_digits("t1", SEG6, EMPTY);

    // Bounce: never low long enough to accept.
    for (int k = 0; k < 8; k++) begin
      pressed = key(8);
      tick(5);
      pressed = '0;
      tick(5);
    end
    tick(20);
    chk("t2_no_valid", 32'(nvalid), 32'd1);
    prev_rows = rows;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (rows !== prev_rows) begin seen = 1'b1; break; end
    end
    chk("t2_rows_moving", 32'(seen), 32'd1);
    r0 = rows;
    chk("t2_rows_onehot", 32'($countones(~r0)), 32'd1);
    tick(3);
    chk("t2_rows_hold_window", 32'(rows), 32'(r0));
    tick(1);
    chk("t2_rows_rotate", 32'(rows), 32'({r0[2:0], r0[3]}));

    // Two clean presses: history shifts.
    n0 = nvalid;
    pressed = key(5);
    wait_valid("t3_wait5");
    chk("t3_code5", 32'(key_code), 32'd5);
    tick(10);
    pressed = '0;
    tick(30);
    pressed = key(10);
    wait_valid("t3_waitA");
    chk("t3_codeA", 32'(key_code), 32'd10);
    tick(10);
    pressed = '0;
    tick(30);
    chk("t3_two_valid", 32'(nvalid), 32'(n0 + 2));
    prev_dig = dig_en;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (dig_en === 2'b01 && prev_dig === 2'b10) begin seen = 1'b1; break; end
      prev_dig = dig_en;
    end
    chk("t3_mux_edge", 32'(seen), 32'd1);
    chk("t3_seg_d0", 32'(segout), 32'(SEGA));
    tick(3);
    chk("t3_dig_hold", 32'(dig_en), 32'(2'b01));
    tick(1);
    chk("t3_dig_next", 32'(dig_en), 32'(2'b10));
    chk("t3_seg_d1", 32'(segout), 32'(SEG5));

    // Hold code 3, add code 12 (other row) while held, release both together.
    n0 = nvalid;
    pressed = key(3);
    wait_valid("t4_wait3");
    tick(5);
    pressed = pressed | key(12);
    tick(10);
    pressed = '0;
    tick(30);
    chk("t4_single_valid", 32'(nvalid), 32'(n0 + 1));
    chk("t4_code", 32'(key_code), 32'd3);
    check_digits("t4", SEG3, SEGA);

    // Reset while DB_PRESS count is 6: align to the start of a row-0 window first.
    n0 = nvalid;
    prev_rows = rows;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (rows === 4'b1110 && prev_rows !== 4'b1110) begin seen = 1'b1; break; end
      prev_rows = rows;
    end
    chk("t5_align", 32'(seen), 32'd1);
    pressed = key(1);
    tick(10);
    reset   = 1'b1;
    pressed = '0;
    tick(1);
    chk("t5_rows", 32'(rows), 32'(4'b1110));
    chk("t5_valid", 32'(key_valid), 32'd0);
    chk("t5_code", 32'(key_code), 32'd0);
    chk("t5_dig_en", 32'(dig_en), 32'(2'b01));
    chk("t5_seg", 32'(segout), 32'(EMPTY));
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("t5_no_strobe", 32'(nvalid), 32'(n0));
    check_digits("t5", EMPTY, EMPTY);

    // One-cycle column drop at DB_RELEASE count 5 sends FSM back to HELD.
    n0 = nvalid;
    pressed = key(9);
    wait_valid("t6_wait9");
    chk("t6_code", 32'(key_code), 32'd9);
    tick(10);
    pressed = '0;
    tick(6);
    pressed = key(9);
    tick(1);
    pressed = '0;
    tick(9);
    chk("t6_held_after_glitch", 32'(rows), 32'(4'b1011));
    tick(5);
    chk("t6_held_full_release", 32'(rows), 32'(4'b1011));
    tick(1);
    chk("t6_scan_resumed", 32'(rows), 32'(4'b0111));
    chk("t6_single_valid", 32'(nvalid), 32'(n0 + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
